// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank: ID and status words (read-only) at
// registers 0 and 1, byte-writable control registers above them. One
// transaction at a time per channel; read and write channels run
// independently.
module axi_lite_regfile #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = 32'hD1C0_0001
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [31:0]              s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,

    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,

    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,

    input  logic [31:0]              s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,

    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,

    input  logic [31:0]              status_in,
    output logic [32*NUM_REGS-1:0]   ctrl_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int unsigned LW = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_RESP } rstate_t;

    // Register storage; entries 0 and 1 are never written and stay zero,
    // which keeps their ctrl_out slices at 0.
    logic [31:0]          r_regs [NUM_REGS];

    wstate_t              r_wstate;
    logic                 r_awready;
    logic                 r_wready;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_aw_held;
    logic [31:0]          r_aw_addr;
    logic                 r_w_held;
    logic [31:0]          r_w_data;
    logic [3:0]           r_w_strb;
    logic [NUM_REGS-1:0]  r_wr_pulse;

    rstate_t              r_rstate;
    logic                 r_arready;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_commit;
    logic [31:0]          w_aw_addr;
    logic [31:0]          w_w_data;
    logic [3:0]           w_w_strb;
    logic [LW-1:0]        w_widx;
    logic                 w_win_range;
    logic                 w_wr_rw;

    logic                 w_ar_hs;
    logic [LW-1:0]        w_ridx;
    logic                 w_rin_range;
    logic [31:0]          w_rdata_mux;
    logic                 w_unused;

    // Readies are registered, so the handshake is simply valid & ready.
    assign w_aw_hs  = s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi_wvalid & r_wready;
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    // A held channel takes priority; otherwise the live bus values are used.
    assign w_aw_addr   = r_aw_held ? r_aw_addr : s_axi_awaddr;
    assign w_w_data    = r_w_held  ? r_w_data  : s_axi_wdata;
    assign w_w_strb    = r_w_held  ? r_w_strb  : s_axi_wstrb;
    assign w_widx      = w_aw_addr[LW+1:2];
    assign w_win_range = (w_aw_addr[31:LW+2] == '0);
    assign w_wr_rw     = w_win_range && (w_widx >= LW'(2));

    assign w_ar_hs     = s_axi_arvalid & r_arready;
    assign w_ridx      = s_axi_araddr[LW+1:2];
    assign w_rin_range = (s_axi_araddr[31:LW+2] == '0);

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[1:0], w_aw_addr[1:0]};

    // Read data selection at the AR handshake (pre-write value on a same-edge commit).
    always_comb begin
        w_rdata_mux = '0;
        if (w_rin_range) begin
            if (w_ridx == LW'(0)) begin
                w_rdata_mux = ID_VALUE;
            end else if (w_ridx == LW'(1)) begin
                w_rdata_mux = status_in;
            end else begin
                w_rdata_mux = r_regs[w_ridx];
            end
        end
    end

    // Write channel FSM: latch AW and W independently, commit when both are present.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_aw_held  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_held   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_wr_pulse <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_win_range ? RESP_OKAY : RESP_SLVERR;
                        if (w_wr_rw) begin
                            for (int unsigned i = 0; i < 4; i++) begin
                                if (w_w_strb[i]) begin
                                    r_regs[w_widx][8*i +: 8] <= w_w_data[8*i +: 8];
                                end
                            end
                            if (|w_w_strb) begin
                                r_wr_pulse[w_widx] <= 1'b1;
                            end
                        end
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_addr <= s_axi_awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_w_data <= s_axi_wdata;
                            r_w_strb <= s_axi_wstrb;
                        end
                        r_awready <= ~(r_aw_held | w_aw_hs);
                        r_wready  <= ~(r_w_held | w_w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read channel FSM: register data and response at the AR handshake, hold until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rdata_mux;
                        r_rresp   <= w_rin_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl
        assign ctrl_out[32*k +: 32] = r_regs[k];
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: vector table, directed corner
// sequences and randomized traffic against a register-map model.
module tb_axi_lite_regfile;

    localparam int unsigned NUM = 16;
    localparam logic [31:0] ID  = 32'hD1C0_0001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      s_axi_awaddr = '0;
    logic [2:0]       s_axi_awprot = '0;
    logic             s_axi_awvalid = 1'b0;
    logic             s_axi_awready;
    logic [31:0]      s_axi_wdata = '0;
    logic [3:0]       s_axi_wstrb = '0;
    logic             s_axi_wvalid = 1'b0;
    logic             s_axi_wready;
    logic [1:0]       s_axi_bresp;
    logic             s_axi_bvalid;
    logic             s_axi_bready = 1'b0;
    logic [31:0]      s_axi_araddr = '0;
    logic [2:0]       s_axi_arprot = '0;
    logic             s_axi_arvalid = 1'b0;
    logic             s_axi_arready;
    logic [31:0]      s_axi_rdata;
    logic [1:0]       s_axi_rresp;
    logic             s_axi_rvalid;
    logic             s_axi_rready = 1'b0;
    logic [31:0]      status_in = '0;
    logic [32*NUM-1:0] ctrl_out;
    logic [NUM-1:0]   wr_pulse;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_regfile #(.NUM_REGS(NUM), .ID_VALUE(ID)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .status_in(status_in), .ctrl_out(ctrl_out), .wr_pulse(wr_pulse)
    );

    // Reference register map: entries 0/1 never written, so they model the zero ctrl slices.
    logic [31:0] m_regs [NUM];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int unsigned dly_aw, input int unsigned dly_w,
                            output logic [1:0] resp, output logic [NUM-1:0] pulse,
                            output logic [32*NUM-1:0] ctrl, output logic bv_at,
                            output logic bv_after, output logic rdy_after, output logic ok);
        int unsigned cyc = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        ok = 1'b1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        while (!(aw_done && w_done)) begin
            s_axi_awvalid = !aw_done && (cyc >= dly_aw);
            s_axi_wvalid  = !w_done && (cyc >= dly_w);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
            if (cyc > 40) begin ok = 1'b0; break; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        resp = s_axi_bresp; pulse = wr_pulse; ctrl = ctrl_out; bv_at = s_axi_bvalid;
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        bv_after = s_axi_bvalid;
        rdy_after = s_axi_awready & s_axi_wready;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                           output logic rv, output logic ok);
        int unsigned cyc = 0;
        bit hs;
        ok = 1'b1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        forever begin
            hs = s_axi_arready;
            tick();
            if (hs) break;
            cyc++;
            if (cyc > 40) begin ok = 1'b0; break; end
        end
        s_axi_arvalid = 1'b0;
        rv = s_axi_rvalid; data = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    function automatic logic [32*NUM-1:0] model_flat();
        logic [32*NUM-1:0] f;
        for (int k = 0; k < NUM; k++) f[32*k +: 32] = m_regs[k];
        return f;
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_val;
        logic [1:0]  exp_resp;
        bit          exp_pulse;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [1:0]  resp;
        logic [NUM-1:0] pulse;
        logic [32*NUM-1:0] ctrl;
        logic        bv_at, bv_after, rdy_after, ok, rv;
        logic [31:0] rdata;
        logic [3:0]  idx;

        vecs[0]  = '{1'b0, 32'h00, 32'h0, 4'h0, ID, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 32'h08, 32'h5A5A5A5A, 4'b0100, 32'h005A0000, 2'b00, 1'b1};
        vecs[3]  = '{1'b0, 32'h08, 32'h0, 4'h0, 32'h005A0000, 2'b00, 1'b0};
        vecs[4]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 32'h04, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00, 1'b0};
        vecs[6]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0, 2'b10, 1'b0};
        vecs[7]  = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 2'b10, 1'b0};
        vecs[8]  = '{1'b1, 32'h3C, 32'h01020304, 4'b0011, 32'h00000304, 2'b00, 1'b1};
        vecs[9]  = '{1'b1, 32'h3C, 32'hAABBCCDD, 4'b0000, 32'h00000304, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 32'h3F, 32'h0, 4'h0, 32'h00000304, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 32'h80000008, 32'h0, 4'h0, 32'h0, 2'b10, 1'b0};

        // Reset behaviour and ready release timing
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ctl", {27'b0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        rst = 1'b0;
        chk("post_rst_ctl", {27'b0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        chk("post_rst_rdata", s_axi_rdata, 32'h0);
        chk("post_rst_resp", {28'b0, s_axi_bresp, s_axi_rresp}, 32'h0);
        chk("post_rst_pulse", {16'b0, wr_pulse}, 32'h0);
        chk("post_rst_ctrl_any", {31'b0, |ctrl_out}, 32'h0);
        tick();
        chk("ready_rise", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

        // Table-driven vectors
        status_in = 32'hCAFEF00D;
        for (int v = 0; v < 12; v++) begin
            idx = vecs[v].addr[5:2];
            if (vecs[v].wr) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, 0, 0,
                         resp, pulse, ctrl, bv_at, bv_after, rdy_after, ok);
                chk($sformatf("vec%0d_ok", v), {31'b0, ok}, 32'h1);
                chk($sformatf("vec%0d_bvalid", v), {31'b0, bv_at}, 32'h1);
                chk($sformatf("vec%0d_bresp", v), {30'b0, resp}, {30'b0, vecs[v].exp_resp});
                chk($sformatf("vec%0d_ctrl", v), ctrl[32*idx +: 32], vecs[v].exp_val);
                chk($sformatf("vec%0d_pulse", v), {16'b0, pulse},
                    vecs[v].exp_pulse ? (32'h1 << idx) : 32'h0);
                chk($sformatf("vec%0d_pulse_1cyc", v), {16'b0, wr_pulse}, 32'h0);
                chk($sformatf("vec%0d_bvalid_drop", v), {31'b0, bv_after}, 32'h0);
                chk($sformatf("vec%0d_ready_back", v), {31'b0, rdy_after}, 32'h1);
            end else begin
                do_read(vecs[v].addr, rdata, resp, rv, ok);
                chk($sformatf("vec%0d_ok", v), {31'b0, ok}, 32'h1);
                chk($sformatf("vec%0d_rvalid", v), {31'b0, rv}, 32'h1);
                chk($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_val);
                chk($sformatf("vec%0d_rresp", v), {30'b0, resp}, {30'b0, vecs[v].exp_resp});
            end
        end

        // W presented 3 cycles ahead of AW
        s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        chk("wfirst_wready", {31'b0, s_axi_wready}, 32'h1);
        tick();
        s_axi_wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("wfirst_no_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
            chk("wfirst_wready_low", {31'b0, s_axi_wready}, 32'h0);
            chk("wfirst_reg3_old", ctrl_out[32*3 +: 32], 32'h0);
            tick();
        end
        s_axi_awaddr = 32'h0C; s_axi_awvalid = 1'b1;
        chk("wfirst_awready", {31'b0, s_axi_awready}, 32'h1);
        tick();
        s_axi_awvalid = 1'b0;
        chk("wfirst_bvalid", {31'b0, s_axi_bvalid}, 32'h1);
        chk("wfirst_reg3", ctrl_out[32*3 +: 32], 32'h12345678);
        chk("wfirst_pulse", {16'b0, wr_pulse}, 32'h8);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        chk("wfirst_single_b", {31'b0, s_axi_bvalid}, 32'h0);

        // Write commit and read of the same register at the same edge
        s_axi_awaddr = 32'h08; s_axi_wdata = 32'hFFFFFFFF; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h08;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        chk("same_edge_readies", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        chk("same_edge_rdata_old", s_axi_rdata, 32'h005A0000);
        chk("same_edge_reg2_new", ctrl_out[32*2 +: 32], 32'hFFFFFFFF);
        chk("same_edge_valids", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;

        // rready held low with status changing: rdata must hold the sampled value
        status_in = 32'h1111_0000;
        s_axi_araddr = 32'h04; s_axi_arvalid = 1'b1;
        chk("hold_arready", {31'b0, s_axi_arready}, 32'h1);
        tick();
        s_axi_arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            status_in = $urandom;
            chk("hold_rvalid", {31'b0, s_axi_rvalid}, 32'h1);
            chk("hold_rdata", s_axi_rdata, 32'h1111_0000);
            chk("hold_arready_low", {31'b0, s_axi_arready}, 32'h0);
            tick();
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        chk("hold_release", {30'b0, s_axi_rvalid, s_axi_arready}, 32'h1);

        // Reset while a write response is pending
        s_axi_awaddr = 32'h10; s_axi_wdata = 32'hA5A5A5A5; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        chk("wresp_pending", {31'b0, s_axi_bvalid}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_drop_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
        chk("rst_clear_reg4", ctrl_out[32*4 +: 32], 32'h0);
        chk("rst_clear_reg2", ctrl_out[32*2 +: 32], 32'h0);
        rst = 1'b0;
        tick();

        // Randomized traffic against the register-map model
        for (int k = 0; k < NUM; k++) m_regs[k] = '0;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, d, exp_d;
            logic [3:0]  s;
            logic [1:0]  exp_r;
            logic [NUM-1:0] exp_p;
            int unsigned mi;
            bit inr;
            a = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = a | 32'h0001_0000;
            inr = (a[31:6] == 0);
            mi = a[5:2];
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_r = inr ? 2'b00 : 2'b10;
                exp_p = '0;
                if (inr && mi >= 2) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) m_regs[mi][8*b +: 8] = d[8*b +: 8];
                    if (s != 0) exp_p = 1 << mi;
                end
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         resp, pulse, ctrl, bv_at, bv_after, rdy_after, ok);
                chk("rnd_w_ok", {31'b0, ok}, 32'h1);
                chk("rnd_w_bvalid", {31'b0, bv_at}, 32'h1);
                chk("rnd_w_bresp", {30'b0, resp}, {30'b0, exp_r});
                chk("rnd_w_pulse", {16'b0, pulse}, {16'b0, exp_p});
                checks++;
                if (ctrl !== model_flat()) begin
                    failures++;
                    $display("FAIL rnd_w_ctrl addr=%h actual=%h required=%h", a, ctrl, model_flat());
                end
            end else begin
                status_in = $urandom;
                if (!inr) begin exp_d = 32'h0; exp_r = 2'b10; end
                else begin
                    exp_r = 2'b00;
                    if (mi == 0) exp_d = ID;
                    else if (mi == 1) exp_d = status_in;
                    else exp_d = m_regs[mi];
                end
                do_read(a, rdata, resp, rv, ok);
                chk("rnd_r_ok", {31'b0, ok}, 32'h1);
                chk("rnd_r_rvalid", {31'b0, rv}, 32'h1);
                chk("rnd_r_rdata", rdata, exp_d);
                chk("rnd_r_rresp", {30'b0, resp}, {30'b0, exp_r});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI4-Lite slave register bank that terminates the master port of the RBCP-to-AXI bridge. It exposes byte-addressable control registers to fabric logic and returns read-only ID and status words. It accepts the single-outstanding, single-byte-strobe traffic the bridge produces. It is also fully compliant for any AXI4-Lite master issuing one transaction at a time per channel.

## Interface
- NUM_REGS, 16, register count; power of two, minimum 4; decoded from addr[log2(NUM_REGS)+1:2]
- ID_VALUE, 32'hD1C0_0001, constant returned by register 0
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_axi_awaddr  in  32, s_axi_awprot  in  3 (ignored), s_axi_awvalid  in  1, s_axi_awready  out  1
- s_axi_wdata  in  32, s_axi_wstrb  in  4, s_axi_wvalid  in  1, s_axi_wready  out  1
- s_axi_bresp  out  2, s_axi_bvalid  out  1, s_axi_bready  in  1
- s_axi_araddr  in  32, s_axi_arprot  in  3 (ignored), s_axi_arvalid  in  1, s_axi_arready  out  1
- s_axi_rdata  out  32, s_axi_rresp  out  2, s_axi_rvalid  out  1, s_axi_rready  in  1
- status_in  in  32  live status word, read at register 1
- ctrl_out  out  32*NUM_REGS  flattened registers, reg k at [32k+31:32k]; slices 0 and 1 are driven 0
- wr_pulse  out  NUM_REGS  one-cycle strobe per register on committed write

## Operation
- Map: reg 0 = ID (RO), reg 1 = status (RO), regs 2..NUM_REGS-1 = RW, reset value 0. Address in range iff addr[31:log2(NUM_REGS)+2] == 0. addr[1:0] is ignored.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = ~aw_held and wready = ~w_held. Each channel is latched independently on its handshake, in either order or in the same cycle.
  - When address and data are both present (held or handshaking now), the write commits on that edge and the FSM moves to W_RESP.
  - W_RESP: awready = wready = 0 and bvalid = 1. The held flags clear on entry. On bvalid & bready, return to W_IDLE.
- Commit rules:
  - RW reg in range: byte lane i is updated from wdata[8i+7:8i] iff wstrb[i]. wr_pulse[k] is set iff wstrb != 0. bresp = OKAY (2'b00).
  - RO reg: no change, no pulse, bresp = OKAY.
  - Out of range: no change, no pulse, bresp = SLVERR (2'b10).
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready = 1. On handshake, rdata and rresp are registered and the FSM moves to R_RESP.
  - R_RESP: arready = 0 and rvalid = 1; rdata and rresp are held stable. On rvalid & rready, return to R_IDLE.
- Read data: reg 0 returns ID_VALUE. Reg 1 returns status_in sampled at the AR handshake edge. RW regs return their current value. Out of range returns 0 with rresp = SLVERR; in range returns rresp = OKAY.
- Read and write channels are independent and may be active concurrently.

## Timing
- While rst is high, and on the first cycle after it: awready = wready = arready = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, wr_pulse = 0, RW regs = 0. Readies rise on the second cycle after rst falls.
- Reset asserted mid-transaction abandons it: held flags clear, pending responses drop, both FSMs return to idle.
- Write latency: completing handshake in cycle N gives a register update visible on ctrl_out in N+1, wr_pulse high for exactly cycle N+1, and bvalid high from N+1.
- Read latency: AR handshake in cycle N gives rvalid and rdata in N+1.
- Back-to-back transactions:
  - bready high in N+1 makes awready/wready high in N+2, so the write throughput floor is 2 cycles per write.
  - Reads follow the same 2-cycle minimum.
  - bvalid and rvalid are held indefinitely while bready or rready is low.
- A write commit and a read handshake at the same edge to the same register: the read returns the pre-write value.
- A second AW while aw_held is set is not accepted (awready = 0); the same applies to W.

## Test plan
- Reset release -> reads return reg 0 = 32'hD1C0_0001 and reg 2 = 0; all readies are 0 in the first post-reset cycle.
- AW addr 0x08 with W wdata 0x5A5A5A5A and wstrb 4'b0100, same cycle -> ctrl_out reg 2 = 0x005A0000 one cycle later, wr_pulse[2] for 1 cycle, bresp OKAY.
- W presented 3 cycles before AW to addr 0x0C, wdata 0x12345678, wstrb 4'hF -> commit only after AW, reg 3 = 0x12345678, exactly one bvalid.
- Write to 0x04 and to 0x40 (NUM_REGS = 16) -> 0x04 gives OKAY with no change and no pulse; 0x40 gives SLVERR; a read of 0x40 gives rdata 0 and SLVERR.
- rready held low for 5 cycles after rvalid with status_in changing -> rdata stays at the value sampled at the AR edge and arready stays 0.
- rst asserted while in W_RESP with bready low -> bvalid = 0 next cycle and reg contents return to 0.
